// File: rtl/vram_pkg.sv
// Shared types and sizes for the video SRAM arbiter: owner tags, bus widths,
// default read latency and the saturating wait-counter helper.
package vram_pkg;

  localparam int VRAM_ADDR_W          = 16;
  localparam int VRAM_DATA_W          = 8;
  localparam int DEFAULT_SRAM_LATENCY = 2;
  localparam int VRAM_WAIT_W          = 4;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  // One slot of the read-return tag pipeline.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_VID};

  function automatic logic [VRAM_WAIT_W-1:0] sat_inc(input logic [VRAM_WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vram_resp_pipe.sv
// Tag shift register that follows each SRAM read through the array latency and
// steers the returning byte to the requester that issued it.
module vram_resp_pipe
  import vram_pkg::*;
#(
  parameter int LATENCY = DEFAULT_SRAM_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  input  owner_e                 issue_owner,
  input  logic [VRAM_DATA_W-1:0] sram_data_out,
  output logic                   vid_rvalid,
  output logic [VRAM_DATA_W-1:0] vid_rdata,
  output logic                   cpu_rvalid,
  output logic [VRAM_DATA_W-1:0] cpu_rdata
);

  tag_t stage [LATENCY];
  tag_t head;
  logic head_vid;
  logic head_cpu;

  assign head     = stage[LATENCY-1];
  assign head_vid = head.valid && (head.owner == OWN_VID);
  assign head_cpu = head.valid && (head.owner == OWN_CPU);

  // Stage 0 is loaded on the issue edge; the last stage lines up with the
  // cycle in which sram_data_out holds the addressed byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= TAG_IDLE;
    end else begin
      stage[0] <= '{valid: issue_valid, owner: issue_owner};
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      vid_rvalid <= head_vid;
      cpu_rvalid <= head_cpu;
      if (head_vid) vid_rdata <= sram_data_out;
      if (head_cpu) cpu_rdata <= sram_data_out;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video SRAM scheduler: video scan-out has priority, the CPU is
// guaranteed a slot after CPU_MAX_WAIT consecutive refusals.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int SRAM_LATENCY = DEFAULT_SRAM_LATENCY,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vid_req,
  input  logic [VRAM_ADDR_W-1:0] vid_addr,
  output logic                   vid_ack,
  output logic                   vid_rvalid,
  output logic [VRAM_DATA_W-1:0] vid_rdata,
  input  logic                   cpu_valid,
  input  logic                   cpu_we,
  input  logic [VRAM_ADDR_W-1:0] cpu_addr,
  input  logic [VRAM_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_rvalid,
  output logic [VRAM_DATA_W-1:0] cpu_rdata,
  output logic [VRAM_ADDR_W-1:0] sram_addr,
  output logic [VRAM_DATA_W-1:0] sram_data_in,
  output logic                   sram_write_enable,
  input  logic [VRAM_DATA_W-1:0] sram_data_out
);

  localparam logic [VRAM_WAIT_W-1:0] WAIT_LIMIT = VRAM_WAIT_W'(CPU_MAX_WAIT);

  logic [VRAM_WAIT_W-1:0] wait_cnt;
  logic                   cpu_force;
  logic                   vid_xfer;
  logic                   cpu_xfer;
  logic                   issue_valid;
  owner_e                 issue_owner;

  // Handshake: a requester holds req/valid with its payload stable until it
  // sees ack/ready high; the transfer happens on the rising edge where both are
  // high. Grants are built from the request inputs only and are held low while
  // reset is asserted.
  always_comb begin
    cpu_force = cpu_valid && (wait_cnt >= WAIT_LIMIT);
    vid_ack   = reset_n && vid_req && !cpu_force;
    cpu_ready = reset_n && cpu_valid && (cpu_force || !vid_req);
  end

  assign vid_xfer    = vid_req && vid_ack;
  assign cpu_xfer    = cpu_valid && cpu_ready;
  assign issue_valid = vid_xfer || (cpu_xfer && !cpu_we);
  assign issue_owner = cpu_xfer ? OWN_CPU : OWN_VID;

  // SRAM command register; address and write data hold through idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr         <= '0;
      sram_data_in      <= '0;
      sram_write_enable <= 1'b0;
    end else begin
      sram_write_enable <= 1'b0;
      if (cpu_xfer) begin
        sram_addr <= cpu_addr;
        if (cpu_we) begin
          sram_write_enable <= 1'b1;
          sram_data_in      <= cpu_wdata;
        end
      end else if (vid_xfer) begin
        sram_addr <= vid_addr;
      end
    end
  end

  // Counts consecutive refused CPU cycles; any grant or idle CPU clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (cpu_valid && !cpu_ready) begin
      wait_cnt <= sat_inc(wait_cnt);
    end else begin
      wait_cnt <= '0;
    end
  end

  vram_resp_pipe #(
    .LATENCY(SRAM_LATENCY)
  ) u_resp_pipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_owner  (issue_owner),
    .sram_data_out(sram_data_out),
    .vid_rvalid   (vid_rvalid),
    .vid_rdata    (vid_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: SRAM behavioural model, arbitration reference model
// and per-owner expected-return queues, with directed and random phases.
module tb_vram_arbiter;

  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_ack;
  logic        vid_rvalid;
  logic [7:0]  vid_rdata;
  logic        cpu_valid = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] sram_addr;
  logic [7:0]  sram_data_in;
  logic        sram_write_enable;
  logic [7:0]  sram_data_out = '0;

  vram_arbiter #(
    .SRAM_LATENCY(LAT),
    .CPU_MAX_WAIT(MAXW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .vid_req          (vid_req),
    .vid_addr         (vid_addr),
    .vid_ack          (vid_ack),
    .vid_rvalid       (vid_rvalid),
    .vid_rdata        (vid_rdata),
    .cpu_valid        (cpu_valid),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_ready        (cpu_ready),
    .cpu_rvalid       (cpu_rvalid),
    .cpu_rdata        (cpu_rdata),
    .sram_addr        (sram_addr),
    .sram_data_in     (sram_data_in),
    .sram_write_enable(sram_write_enable),
    .sram_data_out    (sram_data_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model: address reg in DUT + one data register ----------------
  logic [7:0] sram_mem [65536];
  always @(posedge clk) begin
    if (sram_write_enable) sram_mem[sram_addr] <= sram_data_in;
    sram_data_out <= sram_mem[sram_addr];
  end

  // ---------------- reference model state ----------------
  logic [7:0]  ref_mem [65536];
  logic [39:0] vid_exp_q[$];   // {due cycle, data}
  logic [39:0] cpu_exp_q[$];
  int          m_wait = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_din = '0;
  logic        m_we = 1'b0;
  logic        last_vid_ack = 1'b0;
  logic        last_cpu_ready = 1'b0;
  logic [7:0]  last_vid_rd = '0;
  logic [7:0]  last_cpu_rd = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    sram_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  // ---------------- scoreboard: returned data against expected queues ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    if (!reset_n) begin
      check("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      last_vid_rd = '0;
      last_cpu_rd = '0;
    end else begin
      if (vid_rvalid) begin
        if (vid_exp_q.size() == 0) check("vid_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = vid_exp_q.pop_front();
          check("vid_rdata", 32'(vid_rdata), 32'(e[7:0]));
          check("vid_return_cycle", 32'(cyc), e[39:8]);
        end
        last_vid_rd = vid_rdata;
      end else begin
        check("vid_rdata_hold", 32'(vid_rdata), 32'(last_vid_rd));
      end
      if (cpu_rvalid) begin
        if (cpu_exp_q.size() == 0) check("cpu_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = cpu_exp_q.pop_front();
          check("cpu_rdata", 32'(cpu_rdata), 32'(e[7:0]));
          check("cpu_return_cycle", 32'(cyc), e[39:8]);
        end
        last_cpu_rd = cpu_rdata;
      end else begin
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_cpu_rd));
      end
    end
  end

  // ---------------- driver: one clock with grant and SRAM-command checks ----------------
  task automatic step();
    logic ev, ec;
    @(negedge clk);
    ec = reset_n && cpu_valid && (m_wait >= MAXW || !vid_req);
    ev = reset_n && vid_req && !(cpu_valid && m_wait >= MAXW);
    check("vid_ack", 32'(vid_ack), 32'(ev));
    check("cpu_ready", 32'(cpu_ready), 32'(ec));
    m_we = 1'b0;
    if (ec) begin
      m_addr = cpu_addr;
      if (cpu_we) begin
        ref_mem[cpu_addr] = cpu_wdata;
        m_din = cpu_wdata;
        m_we  = 1'b1;
      end else begin
        cpu_exp_q.push_back({32'(cyc + LAT + 1), ref_mem[cpu_addr]});
      end
    end else if (ev) begin
      m_addr = vid_addr;
      vid_exp_q.push_back({32'(cyc + LAT + 1), ref_mem[vid_addr]});
    end
    if (reset_n && cpu_valid && !ec) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    else m_wait = 0;
    last_vid_ack   = ev;
    last_cpu_ready = ec;
    @(posedge clk);
    #1;
    check("sram_addr", 32'(sram_addr), 32'(m_addr));
    check("sram_write_enable", 32'(sram_write_enable), 32'(m_we));
    check("sram_data_in", 32'(sram_data_in), 32'(m_din));
  endtask

  task automatic set_idle();
    vid_req   = 1'b0;
    cpu_valid = 1'b0;
  endtask

  task automatic do_reset_assert();
    reset_n = 1'b0;
    m_addr = '0;
    m_din  = '0;
    m_we   = 1'b0;
    m_wait = 0;
    vid_exp_q.delete();
    cpu_exp_q.delete();
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d);
    int n;
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_cpu_ready && n < 40);
    if (!last_cpu_ready) check("cpu_grant_timeout", 32'(n), 32'd0);
    cpu_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    set_idle();
    n = 0;
    while ((vid_exp_q.size() + cpu_exp_q.size()) != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_outstanding", 32'(vid_exp_q.size() + cpu_exp_q.size()), 32'd0);
    step();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int refused;
    for (int i = 0; i < 65536; i++) preload(16'(i), 8'($urandom));

    // Reset with random requests: everything must stay low.
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vid_req   = 1'($urandom_range(0, 1));
      vid_addr  = 16'($urandom);
      cpu_valid = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom);
      cpu_wdata = 8'($urandom);
      step();
    end
    check("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    set_idle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // CPU write then read of the same byte on the next cycle.
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8001; cpu_wdata = 8'hA5;
    step();
    check("wr_ready", 32'(last_cpu_ready), 32'd1);
    cpu_we = 1'b0;
    step();
    check("rd_after_wr_ready", 32'(last_cpu_ready), 32'd1);
    check("rd_after_wr_expect", 32'(ref_mem[16'h8001]), 32'hA5);
    drain();

    // Video streaming 0x0000..0x000F.
    for (int i = 0; i < 16; i++) preload(16'(i), 8'(i));
    for (int i = 0; i < 16; i++) begin
      vid_req  = 1'b1;
      vid_addr = 16'(i);
      step();
      check("stream_ack", 32'(last_vid_ack), 32'd1);
    end
    drain();

    // Contention: CPU is refused MAXW cycles, then wins once.
    vid_req = 1'b1; vid_addr = 16'h0100;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    refused = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_cpu_ready) break;
      refused++;
    end
    check("starve_refusals", 32'(refused), 32'(MAXW));
    check("starve_vid_blocked", 32'(last_vid_ack), 32'd0);
    cpu_valid = 1'b0;
    step();
    check("video_resumes", 32'(last_vid_ack), 32'd1);
    step();
    drain();

    // Interleaved owners every cycle.
    preload(16'h7FFF, 8'h3C);
    preload(16'h8000, 8'hC3);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        cpu_valid = 1'b0; vid_req = 1'b1; vid_addr = 16'h7FFF;
      end else begin
        vid_req = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
      end
      step();
    end
    drain();

    // Reset one cycle after a CPU read grant: that read must never return.
    preload(16'h0042, 8'h5A);
    cpu_op(1'b0, 16'h0042, 8'h00);
    step();
    do_reset_assert();
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    cpu_op(1'b0, 16'h0042, 8'h00);
    drain();

    // Random traffic over a small address window to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      if (!vid_req || last_vid_ack) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = 16'h0010 + 16'($urandom_range(0, 3));
      end
      if (!cpu_valid || last_cpu_ready) begin
        cpu_valid = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'h0010 + 16'($urandom_range(0, 3));
        cpu_wdata = 8'($urandom);
      end
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Two-port access scheduler that shares the single-port 64K x 8 video SRAM between a read-only video scan-out requester and a read/write CPU requester. It issues at most one SRAM access per clock. Address, write data and write enable are registered towards the SRAM. Read data is routed back to the owning requester through a tag pipeline matched to the SRAM read latency. Video has priority, and a bounded-wait counter guarantees CPU progress.

Parameters:
SRAM_LATENCY, 2, clock edges from the edge that registers sram_addr to sram_data_out holding that address's data
CPU_MAX_WAIT, 4, consecutive cycles the CPU may be refused before it wins over video; range 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
vid_req  in  1  video read request, held with vid_addr until acked
vid_addr  in  16  video read address
vid_ack  out  1  combinational; high in the cycle video is granted
vid_rvalid  out  1  one-cycle pulse, vid_rdata valid
vid_rdata  out  8  video read data
cpu_valid  in  1  CPU request, held with cpu_addr, cpu_we and cpu_wdata until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_ready  out  1  combinational; high in the cycle the CPU is granted
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid (reads only)
cpu_rdata  out  8  CPU read data
sram_addr  out  16  registered SRAM address
sram_data_in  out  8  registered SRAM write data
sram_write_enable  out  1  registered SRAM write strobe
sram_data_out  in  8  SRAM read data

Behaviour:
- Reset (async assert, sync release): sram_addr=0, sram_data_in=0, sram_write_enable=0, vid_rvalid=0, cpu_rvalid=0, vid_rdata=0, cpu_rdata=0, wait counter=0, all tag stages invalid.
- Grant is decided combinationally each cycle:
  - If cpu_valid and wait_cnt >= CPU_MAX_WAIT, grant CPU.
  - Else if vid_req, grant video.
  - Else if cpu_valid, grant CPU.
  - Else the cycle is idle.
- vid_ack and cpu_ready are never high together. Neither may depend on the other requester's grant output.
- A transfer occurs at edge G when the request is high and its ack/ready is high.
- Issue at G:
  - sram_addr is loaded with the granted address.
  - sram_write_enable = 1 only for a CPU write, otherwise 0.
  - sram_data_in = cpu_wdata on a CPU write; otherwise it holds its previous value.
- Idle cycle: sram_write_enable = 0 and sram_addr holds its value.
- Tag pipeline, SRAM_LATENCY stages of {valid, owner}:
  - A read issued at G enters stage 1 at G and reaches the last stage at G+SRAM_LATENCY-1.
  - At edge G+SRAM_LATENCY, sram_data_out is registered into the owner's rdata and the owner's rvalid is set for exactly one cycle.
  - Writes insert an invalid tag. Throughput is one access per cycle, with any interleaving of owners.
- rdata holds its last value when rvalid is low.
- wait_cnt:
  - Increments (saturating at 15) at each edge where cpu_valid=1 and cpu_ready=0.
  - Clears at each edge where cpu_ready=1 or cpu_valid=0.
- Write followed by a read to the same address on the next cycle returns the newly written byte.
- Addresses are used as given; there is no wrap or offset arithmetic.
- Reset mid-operation flushes the tag pipeline, so no rvalid is produced for accesses in flight.
- Requests changing while unacked is a requester protocol violation; the arbiter samples only at grant.

Decomposition:
- Shared package vram_pkg holds:
  - owner typedef {OWN_VID, OWN_CPU}
  - VRAM_ADDR_W=16 and VRAM_DATA_W=8
  - default SRAM_LATENCY
- One natural sub-module, vram_resp_pipe: the parameterised tag shift register plus response demux, taking {issue_valid, issue_owner, sram_data_out} and producing both rvalid/rdata pairs.

Test Plan:
- Reset: hold reset_n=0 with random inputs. All outputs are 0. Release reset with vid_req=0 and cpu_valid=0: no acks, sram_write_enable stays 0.
- CPU write then read: write 0x8001<-0xA5, then on the next cycle read 0x8001. cpu_ready is high both cycles. sram_write_enable=1 for exactly one cycle. cpu_rvalid pulses 3 edges after the read grant (SRAM_LATENCY=2) with cpu_rdata=0xA5. vid_rvalid is never set.
- Video streaming: vid_req held high with addresses 0x0000..0x000F, preloaded data = address low byte. 16 consecutive acks. vid_rvalid on 16 consecutive cycles with data 0x00..0x0F in order.
- Contention and starvation: vid_req held high plus a CPU read of 0x1234. The CPU is refused for 4 cycles, then cpu_ready=1 on the 5th cycle and vid_ack=0 in that cycle. Video resumes the following cycle. Responses return in issue order to the correct owners.
- Interleaved owners: alternate video reads of 0x7FFF and CPU reads of 0x8000 every cycle. Each rvalid pulse carries its owner's data. No cross-delivery occurs.
- Reset mid-flight: assert reset_n=0 one cycle after a CPU read grant. No cpu_rvalid ever appears for that read. After release, a new read completes normally.
